// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_if : CPU-side holding register and status of the UART receiver
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_rx_if;
   logic [7:0] data_o;
   logic       valid_o;
   logic       read_i;
   logic       clear_i;
   logic       frame_err_o;
   logic       overrun_o;

   modport master (
      output data_o, valid_o, frame_err_o, overrun_o,
      input  read_i, clear_i
   );

   modport slave (
      input  data_o, valid_o, frame_err_o, overrun_o,
      output read_i, clear_i
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with one-entry holding register, sticky flags
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int unsigned FREQ         = 27000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned CLKS_PER_BIT = FREQ / BAUD
) (
   input  logic      clk_i,
   input  logic      rstn_i,
   input  logic      uart_rx_i,
   uart_rx_if.master bus
);

   localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic             sync1;
   logic             rx_s;
   logic             rx_d;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic [7:0]       data;
   logic             valid;
   logic             frame_err;
   logic             overrun;

   logic             fall;
   logic             stop_tick;
   logic             load;
   logic             ovr_set;
   logic             fe_set;

   assign fall      = rx_d & ~rx_s;
   assign stop_tick = (state == STOP) && (baud_cnt == LAST_CNT);
   assign load      = stop_tick & rx_s & (~valid | bus.read_i);
   assign ovr_set   = stop_tick & rx_s & valid & ~bus.read_i;
   assign fe_set    = stop_tick & ~rx_s;

   // Synchronizer plus a third copy for falling-edge detection; idles high.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         sync1 <= uart_rx_i;
         rx_s  <= sync1;
         rx_d  <= rx_s;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (fall) state <= START;
            end
            START: begin
               if (baud_cnt == HALF_CNT) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt <= '0;
                  shift    <= {rx_s, shift[7:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            data  <= shift;
            valid <= 1'b1;
         end else if (bus.read_i) begin
            valid <= 1'b0;
         end
         // A flag being set outranks a simultaneous clear.
         frame_err <= fe_set  | (frame_err & ~bus.clear_i);
         overrun   <= ovr_set | (overrun   & ~bus.clear_i);
      end
   end

   assign bus.data_o      = data;
   assign bus.valid_o     = valid;
   assign bus.frame_err_o = frame_err;
   assign bus.overrun_o   = overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the existing `uart` transmitter. Samples the asynchronous `uart_rx_i` pin, deframes 8N1 characters at a fixed baud rate, and holds each received byte in a one-entry register for the CPU bus to read. It also reports framing errors and overruns as sticky flags. It sits beside `uart` in `top`, fed from the same board RX pin.

## Interface

- `FREQ`, default 27000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bits/s.
- `CLKS_PER_BIT`, default FREQ/BAUD (integer divide, 234 at defaults): clocks per bit.
- `clk_i`, in, 1: single clock.
- `rstn_i`, in, 1: reset. Asynchronous, active-low.
- `uart_rx_i`, in, 1: serial line. Asynchronous; idles high.
- `data_o`, out, 8: last accepted byte.
- `valid_o`, out, 1: `data_o` holds an unread byte.
- `read_i`, in, 1: consumes the held byte. Has effect only while `valid_o` = 1.
- `clear_i`, in, 1: clears both sticky flags.
- `frame_err_o`, out, 1: sticky. A stop bit was sampled low.
- `overrun_o`, out, 1: sticky. A byte was dropped because the holding register was full.

## Operation

- **Synchronizer:** two-flop synchronizer on `uart_rx_i`, reset to 1. All logic uses the synchronized signal `rx_s`. Falling-edge detection compares `rx_s` with a third registered copy.
- **States:** IDLE, START, DATA, STOP. A bit counter runs from 0 to 7 and a baud counter runs from 0 to CLKS_PER_BIT-1.
- **IDLE:**
  - A falling edge on `rx_s` enters START with the baud counter at 0.
  - A line held low (break, or a bad stop bit) does not retrigger; a new start needs a fresh high-to-low edge.
- **START:**
  - When the baud counter reaches CLKS_PER_BIT/2 - 1 (116), sample `rx_s`.
  - If `rx_s` is high, treat it as a glitch and return to IDLE with no flags set.
  - If `rx_s` is low, enter DATA with the baud counter and bit counter at 0.
- **DATA:**
  - Each time the baud counter reaches CLKS_PER_BIT-1, sample `rx_s` into the shift register, LSB first, and restart the baud counter.
  - After the 8th sample, enter STOP.
- **STOP:** when the baud counter reaches CLKS_PER_BIT-1, sample `rx_s` and return to IDLE.
  - If the stop bit is high and `valid_o` = 0, or `read_i` is high in the same cycle: load `data_o` and set `valid_o` to 1.
  - If the stop bit is high, `valid_o` = 1 and `read_i` is low: set `overrun_o`. The byte is dropped and `data_o` is unchanged.
  - If the stop bit is low: set `frame_err_o`, drop the byte, and leave `valid_o` and `data_o` unchanged.
- **Reading:** `read_i` while `valid_o` = 1 clears `valid_o` on the next edge, unless a byte loads in the same cycle, in which case `valid_o` stays 1.
- **Clearing flags:** `clear_i` clears both sticky flags. If a flag is set in the same cycle as `clear_i`, setting wins.
- **Concurrency:** reception continues regardless of the holding register's state. There is no backpressure on the line.

## Timing

- **Reset values:** `data_o` = 0x00, `valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, state = IDLE, counters = 0, synchronizer flops = 1.
- **Reset mid-frame:** any partial frame is discarded. After `rstn_i` releases, the next falling edge starts a new frame.
- **Latency:** a pin edge appears on `rx_s` 2 cycles later. Let the falling edge be detected at cycle t0.
  - The start bit is confirmed at t0+117.
  - Data bit i is sampled at t0+117+234·(i+1).
  - The stop bit is sampled at t0+117+9·234 = t0+2223.
  - `valid_o` and `data_o` update at the edge ending cycle t0+2223, so they are visible from t0+2224. Error flags use the same timing.
- **Outputs:** all outputs are registered. There is no combinational path from `read_i` or `clear_i` to any output.
- **Back-to-back frames:** the receiver returns to IDLE at mid-stop-bit. A start edge arriving half a bit later is caught.
- **Baud tolerance:** about ±4% total mismatch, which follows from mid-bit sampling.

## Test plan

- **Single byte:** send 0xA5 at BAUD with `read_i` low → `valid_o` = 1 and `data_o` = 0xA5 about 2224 cycles after the start edge reaches `rx_s`; both flags stay 0. Pulse `read_i` → `valid_o` = 0 on the next cycle.
- **Glitch rejection:** drive `uart_rx_i` low for 50 cycles, then high → state returns to IDLE; `valid_o`, `frame_err_o` and `overrun_o` all stay 0. A following 0x3C is still received correctly.
- **Framing error:** send 0x55 with the stop bit low → `frame_err_o` = 1, `valid_o` stays 0. `clear_i` → `frame_err_o` = 0.
- **Overrun:** send 0x11, then 0x22 back-to-back with no read → `overrun_o` = 1, `data_o` = 0x11, `valid_o` = 1.
- **Read coincident with completion:** with 0x11 held, assert `read_i` exactly in the stop-sample cycle of 0x22 → `data_o` = 0x22, `valid_o` stays 1, `overrun_o` = 0.
- **Reset mid-frame:** assert `rstn_i` low during data bit 4 of 0xFF, then release → all outputs at reset values. The next frame, 0x81, is received correctly.
